// File: rtl/bash_pkg.sv
// Shared constants and types for the bash line-input front end.
// ASCII codes, FSM encoding and key class bundle.
package bash_pkg;

  localparam logic [7:0] ASC_NUL   = 8'h00;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_PR_LO = 8'h20;
  localparam logic [7:0] ASC_PR_HI = 8'h7E;

  localparam int DEF_MAX_LEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  typedef struct packed {
    logic printable;
    logic backspace;
    logic enter;
    logic other;
  } key_cls_t;

endpackage

// File: rtl/bash_line_buffer_classify.sv
// ascii_classify: one-hot class of a keyboard code.
// key -> cls {printable, backspace, enter, other}.
module ascii_classify
  import bash_pkg::*;
(
  input  logic [7:0] key,
  output key_cls_t   cls
);

  always_comb begin
    cls.printable = (key >= ASC_PR_LO) && (key <= ASC_PR_HI);
    cls.backspace = (key == ASC_BS);
    cls.enter     = (key == ASC_LF) || (key == ASC_CR);
    cls.other     = ~(cls.printable | cls.backspace | cls.enter);
  end

endmodule

// File: rtl/bash_line_buffer.sv
// Editable line buffer: keys in, echo out, line streamed out with NUL.
// Ports: clk, rst_n, key_*, *_require_line, lineOut handshake, echo_*, overflow.
module bash_line_buffer
  import bash_pkg::*;
#(
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int LEN_W      = 13,
  parameter int START_EDIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [7:0]       key_ascii,
  input  logic             in_require_line,
  output logic             out_require_line,
  output logic [7:0]       lineOut,
  output logic             out_newASCII_ready,
  input  logic             lineOut_nextASCII,
  output logic [LEN_W-1:0] out_lineLen,
  output logic             echo_valid,
  output logic [7:0]       echo_ascii,
  output logic             overflow
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LW-1:0] FULL = LW'(MAX_LEN);
  localparam state_t RST_ST =
    (START_EDIT != 0) ? ST_EDIT : ST_IDLE;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] llen_q, llen_d;
  logic          echo_v_d, ovf_d, req_d, wr_en;
  logic [7:0]    echo_a_d;
  logic [7:0]    buf_q [MAX_LEN];
  key_cls_t      cls;

  ascii_classify u_cls (
    .key (key_ascii),
    .cls (cls)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    llen_d   = llen_q;
    echo_v_d = 1'b0;
    echo_a_d = ASC_NUL;
    ovf_d    = 1'b0;
    req_d    = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_require_line) begin
          req_d   = 1'b1;
          len_d   = '0;
          state_d = ST_EDIT;
        end
      end
      ST_EDIT: begin
        if (key_valid) begin
          unique case (1'b1)
            cls.printable: begin
              if (len_q < FULL) begin
                wr_en    = 1'b1;
                len_d    = len_q + 1'b1;
                echo_v_d = 1'b1;
                echo_a_d = key_ascii;
              end else begin
                ovf_d = 1'b1;
              end
            end
            cls.backspace: begin
              if (len_q != '0) begin
                len_d    = len_q - 1'b1;
                echo_v_d = 1'b1;
                echo_a_d = ASC_BS;
              end
            end
            cls.enter: begin
              echo_v_d = 1'b1;
              echo_a_d = ASC_LF;
              llen_d   = len_q;
              idx_d    = '0;
              state_d  = ST_SEND;
            end
            cls.other: ;
          endcase
        end
      end
      ST_SEND: begin
        if (lineOut_nextASCII) begin
          if (idx_q < len_q) begin
            idx_d = idx_q + 1'b1;
          end else begin
            len_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= RST_ST;
      len_q            <= '0;
      idx_q            <= '0;
      llen_q           <= '0;
      echo_valid       <= 1'b0;
      echo_ascii       <= ASC_NUL;
      overflow         <= 1'b0;
      out_require_line <= 1'b0;
    end else begin
      state_q          <= state_d;
      len_q            <= len_d;
      idx_q            <= idx_d;
      llen_q           <= llen_d;
      echo_valid       <= echo_v_d;
      echo_ascii       <= echo_a_d;
      overflow         <= ovf_d;
      out_require_line <= req_d;
    end
  end

  // Line storage is not reset; len_q alone says what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[len_q[AW-1:0]] <= key_ascii;
    end
  end

  assign out_newASCII_ready = (state_q == ST_SEND);
  assign out_lineLen        = LEN_W'(llen_q);
  assign lineOut =
    (out_newASCII_ready && (idx_q < len_q)) ?
    buf_q[idx_q[AW-1:0]] : ASC_NUL;

endmodule

// File: tb/tb_bash_line_buffer.sv
// Randomized + directed bench for bash_line_buffer.
// Reference model: a byte queue plus a mode variable.
module tb_bash_line_buffer;

  localparam int MAX = 32;
  localparam int LW  = 13;
  localparam int M_IDLE = 0;
  localparam int M_EDIT = 1;
  localparam int M_SEND = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_valid = 1'b0;
  logic [7:0]    key_ascii = 8'h00;
  logic          in_require_line = 1'b0;
  logic          lineOut_nextASCII = 1'b0;
  logic          out_require_line;
  logic [7:0]    lineOut;
  logic          out_newASCII_ready;
  logic [LW-1:0] out_lineLen;
  logic          echo_valid;
  logic [7:0]    echo_ascii;
  logic          overflow;

  always #5 clk = ~clk;

  bash_line_buffer #(
    .MAX_LEN    (MAX),
    .LEN_W      (LW),
    .START_EDIT (1)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .key_valid          (key_valid),
    .key_ascii          (key_ascii),
    .in_require_line    (in_require_line),
    .out_require_line   (out_require_line),
    .lineOut            (lineOut),
    .out_newASCII_ready (out_newASCII_ready),
    .lineOut_nextASCII  (lineOut_nextASCII),
    .out_lineLen        (out_lineLen),
    .echo_valid         (echo_valid),
    .echo_ascii         (echo_ascii),
    .overflow           (overflow)
  );

  int vectors = 0;
  int miscompares = 0;
  int mstate;
  int sidx;
  logic [7:0] mline[$];

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic press(input logic [7:0] k);
    logic ev, ov;
    logic [7:0] ea;
    ev = 1'b0;
    ov = 1'b0;
    ea = 8'h00;
    if (mstate == M_EDIT) begin
      if (k >= 8'h20 && k <= 8'h7E) begin
        if (mline.size() < MAX) begin
          mline.push_back(k);
          ev = 1'b1;
          ea = k;
        end else begin
          ov = 1'b1;
        end
      end else if (k == 8'h08) begin
        if (mline.size() > 0) begin
          mline.delete(mline.size() - 1);
          ev = 1'b1;
          ea = 8'h08;
        end
      end else if (k == 8'h0A || k == 8'h0D) begin
        ev = 1'b1;
        ea = 8'h0A;
        mstate = M_SEND;
        sidx = 0;
      end
    end
    key_valid = 1'b1;
    key_ascii = k;
    @(negedge clk);
    key_valid = 1'b0;
    chk("echo_valid", 16'(echo_valid), 16'(ev));
    if (ev) chk("echo_ascii", 16'(echo_ascii), 16'(ea));
    chk("overflow", 16'(overflow), 16'(ov));
    chk("ready_key", 16'(out_newASCII_ready),
        16'(mstate == M_SEND));
  endtask

  task automatic type_str(input string s);
    for (int i = 0; i < s.len(); i++) press(s[i]);
  endtask

  task automatic consume();
    logic [7:0] eb;
    eb = (sidx < mline.size()) ? mline[sidx] : 8'h00;
    chk("ready_pre", 16'(out_newASCII_ready), 16'd1);
    chk("lineOut", 16'(lineOut), 16'(eb));
    chk("lineLen", 16'(out_lineLen), 16'(mline.size()));
    lineOut_nextASCII = 1'b1;
    @(negedge clk);
    lineOut_nextASCII = 1'b0;
    if (sidx < mline.size()) begin
      sidx++;
    end else begin
      mstate = M_IDLE;
      mline.delete();
    end
    chk("ready_post", 16'(out_newASCII_ready),
        16'(mstate == M_SEND));
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i <= MAX + 1 && mstate == M_SEND; i++)
      consume();
  endtask

  task automatic req(input logic with_key);
    logic ex;
    ex = (mstate == M_IDLE);
    in_require_line = 1'b1;
    if (with_key && ex) begin
      key_valid = 1'b1;
      key_ascii = 8'h41;
    end
    @(negedge clk);
    in_require_line = 1'b0;
    key_valid = 1'b0;
    chk("req_ack", 16'(out_require_line), 16'(ex));
    if (ex) begin
      chk("req_key_drop", 16'(echo_valid), 16'd0);
      mstate = M_EDIT;
      mline.delete();
    end
    @(negedge clk);
    chk("req_ack_end", 16'(out_require_line), 16'd0);
  endtask

  task automatic stray();
    lineOut_nextASCII = 1'b1;
    @(negedge clk);
    lineOut_nextASCII = 1'b0;
    chk("stray_ready", 16'(out_newASCII_ready), 16'd0);
    chk("stray_line", 16'(lineOut), 16'd0);
  endtask

  function automatic logic [7:0] gen_key();
    int r;
    r = int'($urandom_range(0, 11));
    if (r < 7) return 8'($urandom_range(32, 126));
    if (r == 7) return 8'h08;
    if (r == 8) return 8'h0D;
    if (r == 9) return 8'h0A;
    if (r == 10) return 8'h7F;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    mstate = M_EDIT;
    sidx = 0;
    #1;
    chk("rst_ready", 16'(out_newASCII_ready), 16'd0);
    chk("rst_line", 16'(lineOut), 16'd0);
    chk("rst_echo", 16'(echo_valid), 16'd0);
    chk("rst_req", 16'(out_require_line), 16'd0);
    chk("rst_len", 16'(out_lineLen), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    type_str("ls");
    press(8'h0D);
    drain();

    req(1'b0);
    type_str("ab");
    press(8'h08);
    type_str("c");
    press(8'h0A);
    drain();

    req(1'b0);
    press(8'h08);
    press(8'h0D);
    drain();

    req(1'b0);
    for (int i = 0; i < MAX + 1; i++)
      press(8'($urandom_range(32, 126)));
    press(8'h0D);
    press(8'h61);
    drain();

    press(8'h7A);
    press(8'h0D);
    stray();
    req(1'b1);
    type_str("pw");
    press(8'h0D);
    press(8'h71);
    in_require_line = 1'b1;
    consume();
    in_require_line = 1'b0;
    drain();

    req(1'b0);
    type_str("xyz");
    press(8'h0D);
    consume();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 16'(out_newASCII_ready), 16'd0);
    chk("rst_mid_line", 16'(lineOut), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mstate = M_EDIT;
    mline.delete();
    press(8'h0D);
    drain();

    req(1'b0);
    for (int n = 0; n < 800; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      case (mstate)
        M_EDIT: begin
          if (r < 8) press(gen_key());
          else if (r == 8) req(1'b0);
          else stray();
        end
        M_SEND: begin
          if (r < 2) press(gen_key());
          else consume();
        end
        default: begin
          if (r < 2) press(gen_key());
          else if (r < 4) stray();
          else req(1'(r % 2));
        end
      endcase
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
